milano_exc_ctrl: RTL and testbench

Trap sequencer for the milano core. On a synchronous exception it flushes the pipeline and serialises the trap-entry CSR updates (mcause, mepc, mtval, mstatus) through the single CSR-file write port, then redirects fetch to mtvec. On `mret` it restores mstatus and redirects fetch to mepc. It sits between decode/execute (exception sources) and the CSR file/IF stage.

---
 rtl/milano_pkg.sv | 34 +++
 rtl/milano_exc_ctrl_if.sv | 28 ++
 rtl/milano_csr_wr_seq.sv | 63 ++++++
 rtl/milano_exc_ctrl.sv | 82 ++++++++
 tb/tb_milano_exc_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/milano_pkg.sv
// milano_pkg: shared types for the milano trap sequencer and mstatus field helpers.
package milano_pkg;
  typedef enum logic [1:0] {IDLE, EXCE, HANDLE, QUIT} exce_hand_state_e;
  typedef enum logic [2:0] {WR_IDLE, WR_MCAUSE, WR_MEPC, WR_MTVAL, WR_MSTATUS} csr_ctrl_state_e;
  typedef enum logic {WR_ENTRY, WR_RETURN} wr_mode_e;
  typedef enum logic [11:0] {
    CSR_NONE    = 12'h000,
    CSR_MSTATUS = 12'h300,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343
  } csr_num_e;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;
  function automatic logic [31:0] mstatus_entry(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction
  function automatic logic [31:0] mstatus_return(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE] = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction
endpackage

// File: rtl/milano_exc_ctrl_if.sv
// milano_exc_ctrl_if: exception sources, CSR write port and IF redirect of the trap sequencer.
interface milano_exc_ctrl_if;
  import milano_pkg::*;
  logic        exc_req_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_tval_i;
  logic        mret_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic        csr_we_o;
  csr_num_e    csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_gnt_i;
  logic        flush_o;
  logic        stall_o;
  logic        pc_set_o;
  logic [31:0] pc_target_o;
  modport slave (
    input  exc_req_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, mtvec_i, mepc_i, mstatus_i, csr_gnt_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, stall_o, pc_set_o, pc_target_o
  );
  modport master (
    output exc_req_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, mtvec_i, mepc_i, mstatus_i, csr_gnt_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, stall_o, pc_set_o, pc_target_o
  );
endinterface

// File: rtl/milano_csr_wr_seq.sv
// milano_csr_wr_seq: serialises trap-entry / mret CSR writes through one granted write port.
// MILANO_MTVAL_EN adds the mtval write between mepc and mstatus.
module milano_csr_wr_seq
  import milano_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  wr_mode_e    mode,
  input  logic [3:0]  cause,
  input  logic [31:0] pc,
`ifdef MILANO_MTVAL_EN
  input  logic [31:0] tval,
`endif
  input  logic [31:0] mstatus,
  input  logic        gnt,
  output logic        we,
  output csr_num_e    waddr,
  output logic [31:0] wdata,
  output logic        done
);
  csr_ctrl_state_e state;
  wr_mode_e mode_q;
  logic [31:0] tval_w;
`ifdef MILANO_MTVAL_EN
  localparam csr_ctrl_state_e AFTER_MEPC = WR_MTVAL;
  assign tval_w = tval;
`else
  localparam csr_ctrl_state_e AFTER_MEPC = WR_MSTATUS;
  assign tval_w = '0;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= WR_IDLE;
      mode_q <= WR_ENTRY;
    end else begin
      case (state)
        WR_IDLE: if (start) begin
          mode_q <= mode;
          state <= mode == WR_ENTRY ? WR_MCAUSE : WR_MSTATUS;
        end
        WR_MCAUSE: if (gnt) state <= WR_MEPC;
        WR_MEPC: if (gnt) state <= AFTER_MEPC;
        WR_MTVAL: if (gnt) state <= WR_MSTATUS;
        WR_MSTATUS: if (gnt) state <= WR_IDLE;
        default: state <= WR_IDLE;
      endcase
    end
  end
  assign we = state != WR_IDLE;
  // done is combinational so the top can redirect in the cycle right after the last grant
  assign done = state == WR_MSTATUS && gnt;
  always_comb begin
    waddr = state == WR_MCAUSE ? CSR_MCAUSE :
            state == WR_MEPC ? CSR_MEPC :
            state == WR_MTVAL ? CSR_MTVAL :
            state == WR_MSTATUS ? CSR_MSTATUS : CSR_NONE;
    wdata = state == WR_MCAUSE ? {28'h0, cause} :
            state == WR_MEPC ? pc & ~32'h1 :
            state == WR_MTVAL ? tval_w :
            state == WR_MSTATUS ? (mode_q == WR_ENTRY ? mstatus_entry(mstatus) : mstatus_return(mstatus)) : '0;
  end
endmodule

// File: rtl/milano_exc_ctrl.sv
// milano_exc_ctrl: trap sequencer - flush, CSR trap-entry/mret writes, fetch redirect.
// MILANO_MTVAL_EN enables the mtval write in the entry sequence.
module milano_exc_ctrl
  import milano_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  milano_exc_ctrl_if.slave bus
);
  exce_hand_state_e state;
  logic [3:0] cause_q;
  logic [31:0] pc_q;
  logic start, done;
  wr_mode_e mode;
  assign start = state == IDLE && (bus.exc_req_i || bus.mret_i);
  assign mode = bus.exc_req_i ? WR_ENTRY : WR_RETURN;
`ifdef MILANO_MTVAL_EN
  logic [31:0] tval_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) tval_q <= '0;
    else if (state == IDLE && bus.exc_req_i) tval_q <= bus.exc_tval_i;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cause_q <= '0;
      pc_q <= '0;
      bus.flush_o <= 1'b0;
      bus.stall_o <= 1'b0;
      bus.pc_set_o <= 1'b0;
      bus.pc_target_o <= '0;
    end else begin
      bus.flush_o <= 1'b0;
      bus.pc_set_o <= 1'b0;
      case (state)
        IDLE: if (bus.exc_req_i) begin
          state <= EXCE;
          cause_q <= bus.exc_cause_i;
          pc_q <= bus.exc_pc_i;
          bus.flush_o <= 1'b1;
          bus.stall_o <= 1'b1;
        end else if (bus.mret_i) begin
          state <= QUIT;
          bus.stall_o <= 1'b1;
        end
        EXCE: if (done) begin
          state <= HANDLE;
          bus.pc_set_o <= 1'b1;
          bus.pc_target_o <= bus.mtvec_i & ~32'h3;
        end
        // mret shares the one-cycle redirect state, with mepc loaded as target
        QUIT: if (done) begin
          state <= HANDLE;
          bus.pc_set_o <= 1'b1;
          bus.pc_target_o <= bus.mepc_i;
        end
        HANDLE: begin
          state <= IDLE;
          bus.stall_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  milano_csr_wr_seq u_seq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (start),
    .mode    (mode),
    .cause   (cause_q),
    .pc      (pc_q),
`ifdef MILANO_MTVAL_EN
    .tval    (tval_q),
`endif
    .mstatus (bus.mstatus_i),
    .gnt     (bus.csr_gnt_i),
    .we      (bus.csr_we_o),
    .waddr   (bus.csr_waddr_o),
    .wdata   (bus.csr_wdata_o),
    .done    (done)
  );
endmodule

// File: tb/tb_milano_exc_ctrl.sv
// tb_milano_exc_ctrl: scoreboard bench for milano_exc_ctrl (flush, CSR writes, redirect, timing).
module tb_milano_exc_ctrl;
`ifdef MILANO_MTVAL_EN
  localparam int MT = 1;
`else
  localparam int MT = 0;
`endif
  typedef struct {
    string       name;
    int          kind;
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  ev_t exp_q[$];
  milano_exc_ctrl_if bus();
  milano_exc_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void push(input string n, input int k, input int c, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.name = n; e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction
  task automatic check_ev(input int kind, input logic [11:0] addr, input logic [31:0] data);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected: got kind=%0d cyc=%0d addr=%h data=%h, want no event", kind, cyc, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.addr != addr || e.data != data) begin
        mismatched++;
        $display("FAIL %s: got kind=%0d cyc=%0d addr=%h data=%h, want kind=%0d cyc=%0d addr=%h data=%h",
                 e.name, kind, cyc, addr, data, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bus.flush_o) check_ev(0, 12'h0, 32'h0);
    if (bus.csr_we_o && !bus.csr_gnt_i) begin
      compared++;
      if (exp_q.size() == 0 || exp_q[0].addr != bus.csr_waddr_o || exp_q[0].data != bus.csr_wdata_o) begin
        mismatched++;
        $display("FAIL hold: got addr=%h data=%h at cyc %0d, want the pending write", bus.csr_waddr_o, bus.csr_wdata_o, cyc);
      end
    end
    if (bus.csr_we_o && bus.csr_gnt_i) check_ev(1, bus.csr_waddr_o, bus.csr_wdata_o);
    if (bus.pc_set_o) check_ev(2, 12'h0, bus.pc_target_o);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_val(input string n, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", n, got, want);
    end
  endtask
  task automatic expect_zero_outputs(input string n);
    expect_val({n, "_we_flush_stall_pcset"}, {28'h0, bus.csr_we_o, bus.flush_o, bus.stall_o, bus.pc_set_o}, 32'h0);
    expect_val({n, "_waddr"}, {20'h0, bus.csr_waddr_o}, 32'h0);
    expect_val({n, "_wdata"}, bus.csr_wdata_o, 32'h0);
    expect_val({n, "_pc_target"}, bus.pc_target_o, 32'h0);
  endtask
  task automatic finish_seq(input string n);
    int k;
    k = 0;
    while (bus.stall_o && k < 40) begin
      step();
      k++;
    end
    if (k == 40) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got stall still high after 40 cycles, want idle", n);
    end
    step();
    expect_val({n, "_pending"}, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask
  task automatic run_exc(input string n, input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] mtvec, input logic [31:0] mst, input logic [31:0] e_mepc,
                         input logic [31:0] e_mst, input logic [31:0] e_tgt, input bit both, input int bp);
    int s;
    s = cyc;
    push({n, "_flush"}, 0, s + 1, 12'h0, 32'h0);
    push({n, "_mcause"}, 1, s + 1, 12'h342, {28'h0, cause});
    push({n, "_mepc"}, 1, s + 2 + bp, 12'h341, e_mepc);
    if (MT == 1) push({n, "_mtval"}, 1, s + 3 + bp, 12'h343, tval);
    push({n, "_mstatus"}, 1, s + 3 + MT + bp, 12'h300, e_mst);
    push({n, "_pc_set"}, 2, s + 4 + MT + bp, 12'h0, e_tgt);
    bus.mtvec_i = mtvec; bus.mstatus_i = mst;
    bus.exc_cause_i = cause; bus.exc_pc_i = pc; bus.exc_tval_i = tval;
    bus.exc_req_i = 1'b1; bus.mret_i = both;
    step();
    bus.exc_req_i = 1'b0; bus.mret_i = 1'b0;
    expect_val({n, "_stall_c1"}, {31'h0, bus.stall_o}, 32'h1);
    if (both) begin
      bus.exc_req_i = 1'b1; bus.exc_cause_i = 4'hf; bus.exc_pc_i = 32'hffff_fff0; bus.exc_tval_i = 32'h5555_5555;
    end
    step();
    bus.exc_req_i = 1'b0;
    if (bp > 0) begin
      bus.csr_gnt_i = 1'b0;
      repeat (bp) step();
      bus.csr_gnt_i = 1'b1;
    end
    finish_seq(n);
  endtask
  task automatic run_mret(input string n, input logic [31:0] mepc, input logic [31:0] mst, input logic [31:0] e_mst);
    int s;
    s = cyc;
    push({n, "_mstatus"}, 1, s + 1, 12'h300, e_mst);
    push({n, "_pc_set"}, 2, s + 2, 12'h0, mepc);
    bus.mepc_i = mepc; bus.mstatus_i = mst;
    bus.mret_i = 1'b1;
    step();
    bus.mret_i = 1'b0;
    expect_val({n, "_stall_c1"}, {31'h0, bus.stall_o}, 32'h1);
    finish_seq(n);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want bench to end");
    $fatal(1);
  end
  initial begin
    int s;
    bus.exc_req_i = 1'b0; bus.exc_cause_i = '0; bus.exc_pc_i = '0; bus.exc_tval_i = '0;
    bus.mret_i = 1'b0; bus.mtvec_i = '0; bus.mepc_i = '0; bus.mstatus_i = '0; bus.csr_gnt_i = 1'b1;
    repeat (2) step();
    expect_zero_outputs("reset");
    rst = 1'b0;
    step();
    expect_zero_outputs("post_reset");
    run_exc("exc_basic", 4'd2, 32'h0000_1004, 32'h0000_0013, 32'h0000_0101, 32'h0000_0008,
            32'h0000_1004, 32'h0000_1880, 32'h0000_0100, 1'b0, 0);
    expect_val("exc_basic_stall_idle", {31'h0, bus.stall_o}, 32'h0);
    run_mret("mret_basic", 32'h0000_1008, 32'h0000_1880, 32'h0000_1888);
    run_exc("exc_bp", 4'd4, 32'h0000_2001, 32'h0000_2001, 32'h0000_0200, 32'h0000_1888,
            32'h0000_2000, 32'h0000_1880, 32'h0000_0200, 1'b0, 3);
    run_exc("exc_both", 4'd11, 32'h2000_0003, 32'hdead_beef, 32'h8000_0003, 32'h0000_0000,
            32'h2000_0002, 32'h0000_1800, 32'h8000_0000, 1'b1, 0);
    run_mret("mret_all", 32'h0000_1234, 32'hffff_fff7, 32'hffff_ffff);
    s = cyc;
    push("rst_mid_flush", 0, s + 1, 12'h0, 32'h0);
    push("rst_mid_mcause", 1, s + 1, 12'h342, 32'h0000_0003);
    push("rst_mid_mepc", 1, s + 2, 12'h341, 32'h0000_3000);
    bus.mtvec_i = 32'h0000_0400; bus.mstatus_i = 32'h0000_0008;
    bus.exc_cause_i = 4'd3; bus.exc_pc_i = 32'h0000_3000; bus.exc_tval_i = 32'h0000_3000;
    bus.exc_req_i = 1'b1;
    step();
    bus.exc_req_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    expect_zero_outputs("rst_mid");
    step();
    rst = 1'b0;
    step();
    expect_zero_outputs("rst_mid_release");
    expect_val("rst_mid_pending", exp_q.size(), 32'h0);
    exp_q.delete();
    run_mret("mret_after_rst", 32'h4000_0000, 32'h0000_0000, 32'h0000_1880);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
